peak_dpu_lsu_ctrl: RTL

//  Load/store sequencer between the DPU decode/execute stage and the data bus. Takes one decoded ld/st op
//  (ls_op codes LB=0 LH=1 LW=2 LBU=3 LHU=4 SB=5 SH=6 SW=7) plus its effective address, checks alignment,

---
 rtl/peak_dpu_lsu_ctrl.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/peak_dpu_lsu_ctrl.sv
// Load/store sequencer between the DPU execute stage and the data bus: alignment check,
// single-outstanding req/gnt/rvld transaction, byte-lane steering, load extension and bus timeout.
module peak_dpu_lsu_ctrl #(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ls_vld_i,
    output logic        ls_rdy_o,
    input  logic [2:0]  ls_op_i,
    input  logic [31:0] ls_addr_i,
    input  logic [31:0] ls_wdata_i,
    input  logic [4:0]  ls_wr_addr_i,
    input  logic        ls_flush_i,
    output logic        ls_done_o,
    output logic        wb_vld_o,
    output logic [4:0]  wb_addr_o,
    output logic [31:0] wb_data_o,
    output logic        ls_err_o,
    output logic [1:0]  ls_err_cause_o,
    output logic        bus_req_o,
    input  logic        bus_gnt_i,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [3:0]  bus_be_o,
    output logic [31:0] bus_wdata_o,
    input  logic        bus_rvld_i,
    input  logic [31:0] bus_rdata_i,
    input  logic        bus_err_i
);

    typedef enum logic [2:0] {
        OP_LB = 3'd0, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW
    } op_e;

    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_e;

    typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_DONE, S_ERR} state_e;

    localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
    localparam logic [1:0] CAUSE_BUS      = 2'b10;
    localparam logic [1:0] CAUSE_TIMEOUT  = 2'b11;
    localparam logic [7:0] CNT_LAST       = 8'(TIMEOUT_CYC - 1);

    state_e      state_q;
    op_e         op_q;
    logic [1:0]  lane_q;
    logic [4:0]  rd_q;
    logic        killed_q;
    logic [7:0]  cnt_q;
    logic        ls_done_q, wb_vld_q, ls_err_q;
    logic [4:0]  wb_addr_q;
    logic [31:0] wb_data_q;
    logic [1:0]  ls_err_cause_q;
    logic        bus_req_q, bus_we_q;
    logic [31:0] bus_addr_q, bus_wdata_q;
    logic [3:0]  bus_be_q;

    size_e       in_size;
    logic        in_store, in_misaligned;
    logic [3:0]  in_be;
    logic [31:0] in_wdata;

    // Decode of the op presented at the input, used only in the accept cycle.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        in_size       = SZ_W;
        in_misaligned = 1'b0;
        in_be         = 4'b1111;
        in_wdata      = ls_wdata_i;
        in_store      = (ls_op_i >= 3'(OP_SB));
        case (op_e'(ls_op_i))
            OP_LB, OP_LBU, OP_SB: in_size = SZ_B;
            OP_LH, OP_LHU, OP_SH: in_size = SZ_H;
            default:              in_size = SZ_W;
        endcase
        case (in_size)
            SZ_B: begin
                in_be    = 4'b0001 << ls_addr_i[1:0];
                in_wdata = {4{ls_wdata_i[7:0]}};
            end
            SZ_H: begin
                in_misaligned = ls_addr_i[0];
                in_be         = 4'b0011 << {ls_addr_i[1], 1'b0};
                in_wdata      = {2{ls_wdata_i[15:0]}};
            end
            default: in_misaligned = |ls_addr_i[1:0];
        endcase
    end

    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [31:0] ld_data;

    always_comb begin
        case (lane_q)
            2'd0:    rd_byte = bus_rdata_i[7:0];
            2'd1:    rd_byte = bus_rdata_i[15:8];
            2'd2:    rd_byte = bus_rdata_i[23:16];
            default: rd_byte = bus_rdata_i[31:24];
        endcase
        rd_half = lane_q[1] ? bus_rdata_i[31:16] : bus_rdata_i[15:0];
        case (op_q)
            OP_LB:   ld_data = {{24{rd_byte[7]}}, rd_byte};
            OP_LBU:  ld_data = {24'd0, rd_byte};
            OP_LH:   ld_data = {{16{rd_half[15]}}, rd_half};
            OP_LHU:  ld_data = {16'd0, rd_half};
            default: ld_data = bus_rdata_i;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            op_q           <= OP_LB;
            lane_q         <= 2'd0;
            rd_q           <= 5'd0;
            killed_q       <= 1'b0;
            cnt_q          <= 8'd0;
            ls_done_q      <= 1'b0;
            wb_vld_q       <= 1'b0;
            wb_addr_q      <= 5'd0;
            wb_data_q      <= 32'd0;
            ls_err_q       <= 1'b0;
            ls_err_cause_q <= 2'b00;
            bus_req_q      <= 1'b0;
            bus_we_q       <= 1'b0;
            bus_addr_q     <= 32'd0;
            bus_be_q       <= 4'd0;
            bus_wdata_q    <= 32'd0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every branch sees start-of-cycle state.
            ls_done_q <= 1'b0;
            wb_vld_q  <= 1'b0;
            ls_err_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (ls_vld_i && !ls_flush_i) begin
                        op_q     <= op_e'(ls_op_i);
                        lane_q   <= ls_addr_i[1:0];
                        rd_q     <= ls_wr_addr_i;
                        killed_q <= 1'b0;
                        if (in_misaligned) begin
                            state_q        <= S_ERR;
                            ls_err_q       <= 1'b1;
                            ls_err_cause_q <= CAUSE_MISALIGN;
                        end else begin
                            state_q     <= S_REQ;
                            cnt_q       <= 8'd0;
                            bus_req_q   <= 1'b1;
                            bus_we_q    <= in_store;
                            bus_addr_q  <= {ls_addr_i[31:2], 2'b00};
                            bus_be_q    <= in_be;
                            bus_wdata_q <= in_wdata;
                        end
                    end
                end
                S_REQ: begin
                    if (ls_flush_i && !bus_gnt_i) begin
                        state_q   <= S_IDLE;
                        bus_req_q <= 1'b0;
                    end else if (bus_gnt_i) begin
                        // A granted access must still be drained, even if it is being flushed.
                        state_q   <= S_WAIT;
                        bus_req_q <= 1'b0;
                        killed_q  <= ls_flush_i;
                        cnt_q     <= cnt_q + 8'd1;
                    end else if (cnt_q >= CNT_LAST) begin
                        state_q        <= S_ERR;
                        bus_req_q      <= 1'b0;
                        ls_err_q       <= 1'b1;
                        ls_err_cause_q <= CAUSE_TIMEOUT;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                S_WAIT: begin
                    if (bus_rvld_i) begin
                        if (killed_q || ls_flush_i) begin
                            state_q <= S_IDLE;
                        end else if (bus_err_i) begin
                            state_q        <= S_ERR;
                            ls_err_q       <= 1'b1;
                            ls_err_cause_q <= CAUSE_BUS;
                        end else begin
                            state_q   <= S_DONE;
                            ls_done_q <= 1'b1;
                            if (op_q < OP_SB) begin
                                wb_vld_q  <= 1'b1;
                                wb_addr_q <= rd_q;
                                wb_data_q <= ld_data;
                            end
                        end
                    end else if (cnt_q >= CNT_LAST) begin
                        if (killed_q || ls_flush_i) begin
                            state_q <= S_IDLE;
                        end else begin
                            state_q        <= S_ERR;
                            ls_err_q       <= 1'b1;
                            ls_err_cause_q <= CAUSE_TIMEOUT;
                        end
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                        if (ls_flush_i) killed_q <= 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign ls_rdy_o       = (state_q == S_IDLE);
    assign ls_done_o      = ls_done_q;
    assign wb_vld_o       = wb_vld_q;
    assign wb_addr_o      = wb_addr_q;
    assign wb_data_o      = wb_data_q;
    assign ls_err_o       = ls_err_q;
    assign ls_err_cause_o = ls_err_cause_q;
    assign bus_req_o      = bus_req_q;
    assign bus_we_o       = bus_we_q;
    assign bus_addr_o     = bus_addr_q;
    assign bus_be_o       = bus_be_q;
    assign bus_wdata_o    = bus_wdata_q;

endmodule
